fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_stack.sv | 24 ++
 rtl/fetch_unit.sv | 58 +++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared Q-phase codes, widths, reset vector and NOP encoding for the fetch path
package fetch_unit_pkg;
   typedef enum logic [1:0] {
      FE_Q1_INCPC = 2'b00,
      FE_Q2_IDLE  = 2'b01,
      FE_Q3_IDLE  = 2'b10,
      FE_Q4_FETCH = 2'b11
   } fe_phase_e;
   localparam int INST_WIDTH = 12;
   localparam int PC_W = 11;
   localparam logic [PC_W-1:0] RESET_VEC = 11'h7FF;
   localparam logic [INST_WIDTH-1:0] NOP = 12'h000;
endpackage

// File: rtl/fetch_unit_stack.sv
// pc_stack: two-level return stack; overflow drops the oldest entry, pops leave the bottom level in place
module pc_stack #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] top_o
);
   logic [W-1:0] lvl1_q, lvl2_q;
   always_ff @(posedge clk)
      if (rst) begin
         lvl1_q <= '0;
         lvl2_q <= '0;
      end else if (push_i) begin
         lvl2_q <= lvl1_q;
         lvl1_q <= din_i;
      end else if (pop_i) begin
         lvl1_q <= lvl2_q;
      end
   assign top_o = lvl1_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and two-cycle branch handling driven by the decoder's Q-phase
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_WIDTH = PC_W,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VEC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            fetchState,
   input  logic [INST_WIDTH-1:0] romData,
   output logic [PC_WIDTH-1:0]   romAddr,
   output logic [INST_WIDTH-1:0] instOut,
   input  logic [1:0]            pageSel,
   input  logic [8:0]            target,
   input  logic                  gotoEn,
   input  logic                  callEn,
   input  logic                  retEn,
   input  logic                  pclWrEn,
   input  logic [7:0]            pclWrData,
   input  logic                  skipReq,
   output logic [7:0]            pclOut
);
   logic [PC_WIDTH-1:0] pc_q, pc_d, stk_top, tgt;
   logic [INST_WIDTH-1:0] ir_q, ir_d;
   logic hold_q, hold_d, q1, q4, br, push, pop;
   pc_stack #(.W(PC_WIDTH)) u_stack (
      .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(pc_q), .top_o(stk_top)
   );
   // holdInc keeps the branch target in place over the next Q1 so the following Q4 fetches it
   always_comb begin
      q1 = fetchState == FE_Q1_INCPC;
      q4 = fetchState == FE_Q4_FETCH;
      br = q4 & (retEn | callEn | gotoEn | pclWrEn);
      pop = q4 & retEn;
      push = q4 & callEn & ~retEn;
      tgt = retEn  ? stk_top :
            callEn ? PC_WIDTH'({pageSel, 1'b0, target[7:0]}) :
            gotoEn ? PC_WIDTH'({pageSel, target}) :
                     PC_WIDTH'({pageSel, 1'b0, pclWrData});
      pc_d = br ? tgt : (q1 & ~hold_q) ? pc_q + 1'b1 : pc_q;
      hold_d = br ? 1'b1 : q1 ? 1'b0 : hold_q;
      ir_d = (br | (q4 & skipReq)) ? NOP : q4 ? romData : ir_q;
   end
   always_ff @(posedge clk)
      if (rst) begin
         pc_q <= RESET_VECTOR;
         ir_q <= NOP;
         hold_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         hold_q <= hold_d;
      end
   assign romAddr = pc_q;
   assign instOut = ir_q;
   assign pclOut = pc_q[7:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phase scenarios plus randomized phase/strobe traffic against a queue-based fetch model
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] fetch_state;
   logic [11:0] rom_data;
   logic [10:0] rom_addr;
   logic [11:0] inst_out;
   logic [1:0] page_sel;
   logic [8:0] target_k;
   logic goto_en, call_en, ret_en, pcl_wr_en, skip_req;
   logic [7:0] pcl_wr_data;
   logic [7:0] pcl_out;
   logic [11:0] rom [2048];
   logic [10:0] m_pc;
   logic [11:0] m_ir;
   logic m_hold;
   logic [10:0] m_stk [$];
   logic [1:0] nxt;
   int n_checks = 0;
   int n_pass = 0;
   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];
   fetch_unit dut (
      .clk(clk), .rst(rst), .fetchState(fetch_state), .romData(rom_data), .romAddr(rom_addr),
      .instOut(inst_out), .pageSel(page_sel), .target(target_k), .gotoEn(goto_en), .callEn(call_en),
      .retEn(ret_en), .pclWrEn(pcl_wr_en), .pclWrData(pcl_wr_data), .skipReq(skip_req), .pclOut(pcl_out)
   );
   // Reference: stack is a queue whose last entry is never removed (the bottom level survives pops)
   task automatic model();
      logic [10:0] nt;
      if (rst) begin
         m_pc = 11'h7FF; m_ir = 12'h000; m_hold = 1'b0; m_stk = {11'h000};
      end else if (fetch_state == 2'd0) begin
         if (m_hold) m_hold = 1'b0;
         else m_pc = m_pc + 11'd1;
      end else if (fetch_state == 2'd3) begin
         if (ret_en | call_en | goto_en | pcl_wr_en) begin
            if (ret_en) begin
               nt = m_stk[0];
               if (m_stk.size() > 1) void'(m_stk.pop_front());
            end else if (call_en) begin
               nt = {page_sel, 1'b0, target_k[7:0]};
               m_stk.push_front(m_pc);
               if (m_stk.size() > 2) void'(m_stk.pop_back());
            end else if (goto_en) nt = {page_sel, target_k};
            else nt = {page_sel, 1'b0, pcl_wr_data};
            m_pc = nt; m_ir = 12'h000; m_hold = 1'b1;
         end else m_ir = skip_req ? 12'h000 : rom[m_pc];
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model();
      #1;
   endtask
   task automatic clear_strobes();
      {goto_en, call_en, ret_en, pcl_wr_en, skip_req} = 5'b0;
   endtask
   task automatic instr(input logic g, c, r, p, s, input logic [8:0] tg, input logic [1:0] pg, input logic [7:0] pd);
      logic [1:0] ph;
      do begin
         ph = nxt;
         fetch_state = ph;
         {goto_en, call_en, ret_en, pcl_wr_en, skip_req} = (ph == 2'd3) ? {g, c, r, p, s} : 5'b0;
         target_k = tg; page_sel = pg; pcl_wr_data = pd;
         tick();
         nxt = nxt + 2'd1;
      end while (ph != 2'd3);
      clear_strobes();
   endtask
   task automatic run(); instr(0, 0, 0, 0, 0, 9'h0, 2'd0, 8'h0); endtask
   task automatic do_reset();
      rst = 1'b1; fetch_state = 2'($urandom_range(0, 3)); tick(); rst = 1'b0; nxt = 2'd1;
   endtask
   task automatic test_reset();
      clear_strobes(); target_k = '0; page_sel = '0; pcl_wr_data = '0;
      do_reset();
      n_checks++; if (rom_addr !== 11'h7FF) $display("FAIL reset_addr got %h want 7ff", rom_addr); else n_pass++;
      n_checks++; if (pcl_out !== 8'hFF) $display("FAIL reset_pcl got %h want ff", pcl_out); else n_pass++;
      n_checks++; if (inst_out !== 12'h000) $display("FAIL reset_inst got %h want 000", inst_out); else n_pass++;
   endtask
   task automatic test_free_run();
      logic [10:0] ea [3] = '{11'h7FF, 11'h000, 11'h001};
      for (int i = 0; i < 3; i++) begin
         run();
         n_checks++; if (rom_addr !== ea[i]) $display("FAIL free_run_addr%0d got %h want %h", i, rom_addr, ea[i]); else n_pass++;
         n_checks++; if (inst_out !== {1'b1, ea[i]}) $display("FAIL free_run_inst%0d got %h want %h", i, inst_out, {1'b1, ea[i]}); else n_pass++;
      end
   endtask
   task automatic test_wrap();
      instr(1, 0, 0, 0, 0, 9'h1FF, 2'd3, 8'h0);
      n_checks++; if (inst_out !== 12'h000) $display("FAIL wrap_goto_nop got %h want 000", inst_out); else n_pass++;
      run();
      n_checks++; if (rom_addr !== 11'h7FF) $display("FAIL wrap_7ff got %h want 7ff", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'hFFF) $display("FAIL wrap_7ff_inst got %h want fff", inst_out); else n_pass++;
      run();
      n_checks++; if (rom_addr !== 11'h000) $display("FAIL wrap_000 got %h want 000", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'h800) $display("FAIL wrap_000_inst got %h want 800", inst_out); else n_pass++;
   endtask
   task automatic test_call_ret();
      instr(1, 0, 0, 0, 0, 9'h005, 2'd0, 8'h0);
      instr(0, 1, 0, 0, 0, 9'h040, 2'd0, 8'h0);
      n_checks++; if (inst_out !== 12'h000) $display("FAIL call_nop got %h want 000", inst_out); else n_pass++;
      run();
      n_checks++; if (rom_addr !== 11'h040) $display("FAIL call_fetch got %h want 040", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'h840) $display("FAIL call_fetch_inst got %h want 840", inst_out); else n_pass++;
      run();
      instr(0, 0, 1, 0, 0, 9'h0, 2'd0, 8'h0);
      n_checks++; if (inst_out !== 12'h000) $display("FAIL ret_nop got %h want 000", inst_out); else n_pass++;
      run();
      n_checks++; if (rom_addr !== 11'h005) $display("FAIL ret_fetch got %h want 005", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'h805) $display("FAIL ret_fetch_inst got %h want 805", inst_out); else n_pass++;
   endtask
   task automatic test_nested();
      logic [10:0] er [3] = '{11'h030, 11'h020, 11'h020};
      instr(1, 0, 0, 0, 0, 9'h010, 2'd0, 8'h0);
      instr(0, 1, 0, 0, 0, 9'h020, 2'd0, 8'h0);
      instr(0, 1, 0, 0, 0, 9'h030, 2'd0, 8'h0);
      instr(0, 1, 0, 0, 0, 9'h050, 2'd0, 8'h0);
      for (int i = 0; i < 3; i++) begin
         instr(0, 0, 1, 0, 0, 9'h0, 2'd0, 8'h0);
         n_checks++; if (rom_addr !== er[i]) $display("FAIL nested_ret%0d got %h want %h", i, rom_addr, er[i]); else n_pass++;
      end
   endtask
   task automatic test_skip();
      rom[11'h101] = 12'hA55;
      instr(1, 0, 0, 0, 0, 9'h100, 2'd0, 8'h0);
      run();
      instr(0, 0, 0, 0, 1, 9'h0, 2'd0, 8'h0);
      n_checks++; if (inst_out !== 12'h000) $display("FAIL skip_nop got %h want 000", inst_out); else n_pass++;
      n_checks++; if (rom_addr !== 11'h101) $display("FAIL skip_addr got %h want 101", rom_addr); else n_pass++;
      run();
      n_checks++; if (rom_addr !== 11'h102) $display("FAIL skip_next got %h want 102", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'h902) $display("FAIL skip_next_inst got %h want 902", inst_out); else n_pass++;
      instr(1, 0, 0, 0, 1, 9'h080, 2'd0, 8'h0);
      n_checks++; if (rom_addr !== 11'h080) $display("FAIL skip_goto_addr got %h want 080", rom_addr); else n_pass++;
      run();
      n_checks++; if (inst_out !== 12'h880) $display("FAIL skip_goto_inst got %h want 880", inst_out); else n_pass++;
   endtask
   task automatic test_priority();
      instr(0, 0, 0, 1, 0, 9'h0, 2'd1, 8'h77);
      n_checks++; if (rom_addr !== 11'h277) $display("FAIL pclwr_addr got %h want 277", rom_addr); else n_pass++;
      instr(1, 0, 0, 1, 0, 9'h033, 2'd1, 8'h77);
      n_checks++; if (rom_addr !== 11'h233) $display("FAIL goto_over_pclwr got %h want 233", rom_addr); else n_pass++;
   endtask
   task automatic test_reset_mid();
      instr(0, 1, 0, 0, 0, 9'h060, 2'd0, 8'h0);
      {goto_en, call_en, ret_en, pcl_wr_en} = 4'b1111; target_k = 9'h1AA; page_sel = 2'd2;
      fetch_state = 2'd0; tick();
      fetch_state = 2'd1; tick();
      n_checks++; if (rom_addr !== 11'h060) $display("FAIL early_strobe_ignored got %h want 060", rom_addr); else n_pass++;
      fetch_state = 2'd2; rst = 1'b1; tick(); rst = 1'b0; clear_strobes();
      n_checks++; if (rom_addr !== 11'h7FF) $display("FAIL mid_reset_addr got %h want 7ff", rom_addr); else n_pass++;
      n_checks++; if (inst_out !== 12'h000) $display("FAIL mid_reset_inst got %h want 000", inst_out); else n_pass++;
      nxt = 2'd3;
      instr(0, 0, 1, 0, 0, 9'h0, 2'd0, 8'h0);
      n_checks++; if (rom_addr !== 11'h000) $display("FAIL stack_cleared got %h want 000", rom_addr); else n_pass++;
   endtask
   task automatic test_random();
      for (int a = 0; a < 2048; a++) rom[a] = 12'($urandom);
      do_reset();
      for (int i = 0; i < 800; i++) begin
         fetch_state = nxt;
         rst = ($urandom_range(0, 79) == 0);
         goto_en = ($urandom_range(0, 5) == 0);
         call_en = ($urandom_range(0, 5) == 0);
         ret_en = ($urandom_range(0, 5) == 0);
         pcl_wr_en = ($urandom_range(0, 5) == 0);
         skip_req = ($urandom_range(0, 3) == 0);
         target_k = 9'($urandom); page_sel = 2'($urandom); pcl_wr_data = 8'($urandom);
         tick();
         nxt = nxt + 2'd1;
         n_checks++; if (rom_addr !== m_pc) $display("FAIL rand_addr cyc %0d got %h want %h", i, rom_addr, m_pc); else n_pass++;
         n_checks++; if (inst_out !== m_ir) $display("FAIL rand_inst cyc %0d got %h want %h", i, inst_out, m_ir); else n_pass++;
         n_checks++; if (pcl_out !== m_pc[7:0]) $display("FAIL rand_pcl cyc %0d got %h want %h", i, pcl_out, m_pc[7:0]); else n_pass++;
      end
      rst = 1'b0; clear_strobes();
   endtask
   initial begin
      for (int a = 0; a < 2048; a++) rom[a] = {1'b1, 11'(a)};
      rst = 1'b0; fetch_state = 2'd1; nxt = 2'd1;
      m_pc = '0; m_ir = '0; m_hold = 1'b0; m_stk = {11'h000};
      test_reset();
      test_free_run();
      test_wrap();
      test_call_ret();
      test_nested();
      test_skip();
      test_priority();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
